// File: rtl/kare_pkg.sv
// Shared types and widths for the kare round-robin squaring arbiter.
package kare_pkg;

  localparam int SQ_IN_W  = 4;
  localparam int SQ_OUT_W = 8;
  localparam int ACC_W    = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/kare_rr_sec.sv
// Combinational round-robin picker: the first valid requester after last_grant wins.
module kare_rr_sec #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    int  c;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = (int'(last_grant) + k) % N_REQ;
      if (!found && req_valid[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = ID_W'(c);
      end
    end
  end

endmodule

// File: rtl/kare_sq4.sv
// Combinational 4-bit unsigned squarer built from shifted partial products.
import kare_pkg::*;

module kare_sq4 (
  input  logic [SQ_IN_W-1:0]  i_a,
  output logic [SQ_OUT_W-1:0] o_sq
);

  always_comb begin
    o_sq = '0;
    for (int i = 0; i < SQ_IN_W; i++) begin
      if (i_a[i]) o_sq = o_sq + (SQ_OUT_W'(i_a) << i);
    end
  end

endmodule

// File: rtl/kare_arbiter_4bit.sv
// Round-robin arbiter that squares the granted 4-bit operand and returns it with its owner id.
// Optional result accumulator (ports acc_clr/acc_sum) is built when KARE_ACC_EN is defined.
//
//   state   | meaning
//   IDLE    | offer req_ready to the round-robin winner, latch its operand on handshake
//   CALC    | register the square and owner id
//   DONE    | hold res_valid/res_f/res_id until res_ready
import kare_pkg::*;

module kare_arbiter_4bit #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [SQ_IN_W*N_REQ-1:0] req_a,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SQ_OUT_W-1:0]      res_f,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy
`ifdef KARE_ACC_EN
  ,
  input  logic                     acc_clr,
  output logic [ACC_W-1:0]         acc_sum
`endif
);

  state_t                r_state;
  logic [ID_W-1:0]       r_last_grant;
  logic [SQ_IN_W-1:0]    r_op;
  logic [ID_W-1:0]       r_id;
  logic [SQ_OUT_W-1:0]   r_res_f;
  logic [ID_W-1:0]       r_res_id;

  logic [N_REQ-1:0]      w_grant;
  logic [ID_W-1:0]       w_idx;
  logic [SQ_IN_W-1:0]    w_op;
  logic [SQ_OUT_W-1:0]   w_sq;
  logic                  w_req_hs;
  logic                  w_res_hs;

  kare_rr_sec #(.N_REQ(N_REQ), .ID_W(ID_W)) u_rr (
    .req_valid  (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .idx        (w_idx)
  );

  kare_sq4 u_sq (
    .i_a  (r_op),
    .o_sq (w_sq)
  );

  assign w_op = req_a[SQ_IN_W*int'(w_idx) +: SQ_IN_W];

  // Outputs are forced quiet while rst is high, even before the reset edge lands.
  assign req_ready = (r_state == ST_IDLE && !rst) ? w_grant : '0;
  assign res_valid = (r_state == ST_DONE) && !rst;
  assign busy      = (r_state != ST_IDLE) && !rst;
  assign res_f     = r_res_f;
  assign res_id    = r_res_id;

  assign w_req_hs  = |req_ready;
  assign w_res_hs  = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= ID_W'(N_REQ - 1);
      r_op         <= '0;
      r_id         <= '0;
      r_res_f      <= '0;
      r_res_id     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_hs) begin
            r_op         <= w_op;
            r_id         <= w_idx;
            r_last_grant <= w_idx;
            r_state      <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_res_f  <= w_sq;
          r_res_id <= r_id;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (w_res_hs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef KARE_ACC_EN
  logic [ACC_W-1:0] r_acc;

  // A clear that lands on a result handshake restarts the sum at that result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_res_hs) begin
      r_acc <= acc_clr ? ACC_W'(r_res_f) : r_acc + ACC_W'(r_res_f);
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end

  assign acc_sum = r_acc;
`endif

endmodule

// File: tb/tb_kare_arbiter_4bit.sv
// Self-checking bench for kare_arbiter_4bit: vector table plus scoreboard of expected results.
`timescale 1ns/1ps
module tb_kare_arbiter_4bit;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_f;
  logic [1:0]  res_id;
  logic        busy;
  logic        acc_clr;
`ifdef KARE_ACC_EN
  logic [11:0] acc_sum;
`endif

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] f;
  } exp_t;

  typedef struct {
    logic [3:0]  v;
    logic [15:0] a;
    logic [3:0]  g;
    logic [1:0]  id;
    logic [7:0]  f;
  } vec_t;

  exp_t exp_q[$];

  kare_arbiter_4bit #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_f     (res_f),
    .res_id    (res_id),
    .busy      (busy)
`ifdef KARE_ACC_EN
    ,
    .acc_clr   (acc_clr),
    .acc_sum   (acc_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result-side monitor: a handshake at the coming edge retires the oldest expectation.
  always @(negedge clk) begin
    if (res_valid === 1'b1 && res_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got res_f=%0d res_id=%0d expected no result", res_f, res_id);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_res_f", res_f, e.f);
        check("sb_res_id", res_id, e.id);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    res_ready = 1'b0;
    acc_clr = 1'b0;
    #1;
    check("rst_ready_during", req_ready, 4'h0);
    tick();
    check("rst_ready", req_ready, 4'h0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    req_valid = 4'h0;
    #1;
    check("rst_res_f", res_f, 8'd0);
    check("rst_res_id", res_id, 2'd0);
    check("rst_busy_after", busy, 1'b0);
    exp_q.delete();
  endtask

  // One full transaction: IDLE grant, CALC with scrambled inputs, DONE with res_ready.
  task automatic run_one(input logic [3:0] v, input logic [15:0] a, input logic [3:0] g,
                         input logic [1:0] id, input logic [7:0] f, input logic clr);
    exp_t e;
    req_valid = v;
    req_a = a;
    res_ready = 1'b1;
    acc_clr = 1'b0;
    #1;
    check("grant", req_ready, g);
    check("busy_idle", busy, 1'b0);
    e.id = id;
    e.f = f;
    exp_q.push_back(e);
    tick();
    req_valid = 4'hF;
    req_a = 16'hFFFF;
    check("ready_calc", req_ready, 4'h0);
    check("busy_calc", busy, 1'b1);
    check("res_valid_calc", res_valid, 1'b0);
    tick();
    acc_clr = clr;
    check("res_valid_done", res_valid, 1'b1);
    check("ready_done", req_ready, 4'h0);
    tick();
    acc_clr = 1'b0;
    req_valid = 4'h0;
    check("busy_back_idle", busy, 1'b0);
  endtask

  initial begin
    vec_t vecs[10];
    exp_t e;
    rst = 1'b1;
    req_valid = 4'h0;
    req_a = 16'h0;
    res_ready = 1'b0;
    acc_clr = 1'b0;

    vecs[0] = '{4'b1111, 16'h9753, 4'b0001, 2'd0, 8'd9};
    vecs[1] = '{4'b1111, 16'h9753, 4'b0010, 2'd1, 8'd25};
    vecs[2] = '{4'b1111, 16'h9753, 4'b0100, 2'd2, 8'd49};
    vecs[3] = '{4'b1111, 16'h9753, 4'b1000, 2'd3, 8'd81};
    vecs[4] = '{4'b1111, 16'h9753, 4'b0001, 2'd0, 8'd9};
    vecs[5] = '{4'b0100, 16'h0000, 4'b0100, 2'd2, 8'd0};
    vecs[6] = '{4'b1010, 16'hC0B0, 4'b1000, 2'd3, 8'd144};
    vecs[7] = '{4'b0011, 16'h00E1, 4'b0001, 2'd0, 8'd1};
    vecs[8] = '{4'b1110, 16'h4321, 4'b0010, 2'd1, 8'd4};
    vecs[9] = '{4'b0001, 16'h000A, 4'b0001, 2'd0, 8'd100};

    do_reset();
    run_one(4'b0001, 16'h000F, 4'b0001, 2'd0, 8'd225, 1'b0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].v, vecs[i].a, vecs[i].g, vecs[i].id, vecs[i].f, 1'b0);
    end

    // A request that drops before any edge leaves the arbiter idle.
    req_valid = 4'b0000;
    res_ready = 1'b1;
    tick();
    check("idle_no_req_ready", req_ready, 4'h0);
    check("idle_no_req_busy", busy, 1'b0);

    // Backpressure: result must hold while the consumer stalls.
    req_valid = 4'b0010;
    req_a = 16'h00D0;
    res_ready = 1'b0;
    #1;
    check("bp_grant", req_ready, 4'b0010);
    e.id = 2'd1;
    e.f = 8'd169;
    exp_q.push_back(e);
    tick();
    req_valid = 4'hF;
    req_a = 16'h1234;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_res_f", res_f, 8'd169);
      check("bp_ready", req_ready, 4'h0);
      tick();
    end
    res_ready = 1'b1;
    check("bp_res_valid_last", res_valid, 1'b1);
    tick();
    req_valid = 4'h0;
    check("bp_idle_busy", busy, 1'b0);
    check("bp_idle_res_valid", res_valid, 1'b0);

    // Reset in CALC discards the result and restores requester 0 priority.
    req_valid = 4'b0100;
    req_a = 16'h0400;
    #1;
    check("mid_grant", req_ready, 4'b0100);
    tick();
    check("mid_busy_calc", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    req_valid = 4'h0;
    #1;
    check("mid_after_busy", busy, 1'b0);
    check("mid_after_res_valid", res_valid, 1'b0);
    run_one(4'b0101, 16'h0406, 4'b0001, 2'd0, 8'd36, 1'b0);

`ifdef KARE_ACC_EN
    do_reset();
    check("acc_reset", acc_sum, 12'd0);
    for (int i = 0; i < 19; i++) begin
      run_one(4'b0001, 16'h000F, 4'b0001, 2'd0, 8'd225, 1'b0);
    end
    check("acc_19x225", acc_sum, 12'd179);
    run_one(4'b0001, 16'h0002, 4'b0001, 2'd0, 8'd4, 1'b1);
    check("acc_clr_hs", acc_sum, 12'd4);
`endif

    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
